// File: rtl/sdr_pkg.sv
// Shared SDR definitions: DAC output modes and the attenuation control width.
package sdr_pkg;

  localparam int ATTEN_W = 3;

  typedef enum logic {
    DAC_MODE_PWM = 1'b0,
    DAC_MODE_SD  = 1'b1
  } dac_mode_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers so full and empty are distinguished
// without a separate counter. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     RSTb,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  assign o_level = r_wrPtr - r_rdPtr;
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (o_level == (AW+1)'(DEPTH));
  assign o_data  = r_mem[r_rdPtr[AW-1:0]];

  // Sample storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_data;
    end
  end

  // Read and write pointers, including the extra wrap bit.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/audio_dac_out.sv
// Audio output stage: buffers detector samples, attenuates them once per period and
// drives a 1-bit DAC either as PWM or as a first-order sigma-delta bitstream.
module audio_dac_out
  import sdr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   RSTb,
  input  logic [WIDTH-1:0]       in_sample,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [ATTEN_W-1:0]     atten,
  input  logic                   underrun_clr,
  output logic                   pwm_out,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   period_strobe
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_dutyQ;
  dac_mode_e        r_modeQ;
  logic [WIDTH-1:0] r_acc;
  logic             r_pwm;
  logic             r_underrun;
  logic             r_strobe;

  logic             w_boundary;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_fifoData;
  logic [WIDTH-1:0] w_newDuty;
  dac_mode_e        w_newMode;
  logic             w_modeSwitch;
  logic [WIDTH:0]   w_sdSum;

  assign w_boundary   = (r_count == {WIDTH{1'b1}});
  assign w_push       = in_valid && !w_full;
  assign w_pop        = w_boundary && !w_empty;
  assign w_newDuty    = w_fifoData >> atten;
  assign w_newMode    = dac_mode_e'(mode);
  assign w_modeSwitch = w_pop && (w_newMode != r_modeQ);
  assign w_sdSum      = {1'b0, r_acc} + {1'b0, r_dutyQ};

  assign in_ready      = !w_full;
  assign pwm_out       = r_pwm;
  assign underrun      = r_underrun;
  assign period_strobe = r_strobe;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .RSTb    (RSTb),
    .i_push  (w_push),
    .i_data  (in_sample),
    .i_pop   (w_pop),
    .o_data  (w_fifoData),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Free-running period counter; its all-ones value marks the period boundary.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) r_count <= '0;
    else       r_count <= r_count + 1'b1;
  end

  // Latch a new duty and mode only at a boundary that has a sample; otherwise hold.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      r_dutyQ <= '0;
      r_modeQ <= DAC_MODE_PWM;
    end else if (w_pop) begin
      r_dutyQ <= w_newDuty;
      r_modeQ <= w_newMode;
    end
  end

  // Sigma-delta accumulator; the carry of each sum goes straight to the output
  // register, and the accumulator restarts from zero whenever the mode changes.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      r_acc <= '0;
    end else if (w_modeSwitch || (r_modeQ == DAC_MODE_PWM)) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_sdSum[WIDTH-1:0];
    end
  end

  // Registered DAC bit: compare against the period count in PWM, carry in sigma-delta.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      r_pwm <= 1'b0;
    end else if (r_modeQ == DAC_MODE_SD) begin
      r_pwm <= w_sdSum[WIDTH];
    end else begin
      r_pwm <= (r_count < r_dutyQ);
    end
  end

  // Sticky underrun: an empty boundary sets it and takes priority over a clear.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      r_underrun <= 1'b0;
    end else if (w_boundary && w_empty) begin
      r_underrun <= 1'b1;
    end else if (underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  // One-cycle pulse in the first cycle of every period.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) r_strobe <= 1'b0;
    else       r_strobe <= w_boundary;
  end

endmodule

// File: tb/tb_audio_dac_out.sv
// Directed bench for audio_dac_out (WIDTH=8, DEPTH=4): PWM duty, attenuation,
// sigma-delta density, FIFO full/simultaneous push-pop, underrun and async reset.
module tb_audio_dac_out;

  logic       clk;
  logic       RSTb;
  logic [7:0] inSample;
  logic       inValid;
  logic       inReady;
  logic       modeIn;
  logic [2:0] atten;
  logic       underrunClr;
  logic       pwmOut;
  logic       underrun;
  logic [2:0] fifoLevel;
  logic       periodStrobe;

  int vectors    = 0;
  int miscompares = 0;
  int cyc;

  audio_dac_out #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk           (clk),
    .RSTb          (RSTb),
    .in_sample     (inSample),
    .in_valid      (inValid),
    .in_ready      (inReady),
    .mode          (modeIn),
    .atten         (atten),
    .underrun_clr  (underrunClr),
    .pwm_out       (pwmOut),
    .underrun      (underrun),
    .fifo_level    (fifoLevel),
    .period_strobe (periodStrobe)
  );

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side image of the period counter: clocks seen since reset released.
  always @(posedge clk or negedge RSTb) begin
    if (!RSTb) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Guard against a stuck run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] sample, input logic valid,
                               input logic m, input logic [2:0] a);
    inSample = sample;
    inValid  = valid;
    modeIn   = m;
    atten    = a;
  endtask

  task automatic goToCount(input int target);
    while ((cyc % 256) != target) @(negedge clk);
  endtask

  // Samples pwm_out over one whole period starting at a count==0 negedge,
  // optionally presenting one sample at a chosen offset within the period.
  task automatic measurePeriod(input bit doPush, input int pushAt, input logic [7:0] pushVal,
                               output int highs, output bit adjacent, output logic firstOut);
    logic prev;
    highs    = 0;
    adjacent = 1'b0;
    prev     = 1'b0;
    firstOut = 1'b0;
    if (doPush && pushAt == 0) begin
      inSample = pushVal;
      inValid  = 1'b1;
    end
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i == 1) firstOut = pwmOut;
      if (pwmOut === 1'b1) begin
        highs++;
        if (prev) adjacent = 1'b1;
      end
      prev = (pwmOut === 1'b1);
      if (inValid && i == pushAt + 1) inValid = 1'b0;
      if (doPush && i == pushAt) begin
        inSample = pushVal;
        inValid  = 1'b1;
      end
    end
  endtask

  initial begin
    int   highs;
    bit   adj;
    logic first;

    RSTb        = 1'b0;
    underrunClr = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 3'd0);
    repeat (3) @(negedge clk);

    checkOutput("reset_pwm",      pwmOut, 0);
    checkOutput("reset_underrun", underrun, 0);
    checkOutput("reset_strobe",   periodStrobe, 0);
    checkOutput("reset_level",    fifoLevel, 0);
    checkOutput("reset_ready",    inReady, 1);

    // Release reset and push 0x40 in PWM mode, no attenuation.
    RSTb = 1'b1;
    applyStimulus(8'h40, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("push1_level", fifoLevel, 1);

    goToCount(0);
    checkOutput("b1_strobe",   periodStrobe, 1);
    checkOutput("b1_level",    fifoLevel, 0);
    checkOutput("b1_pwm",      pwmOut, 0);
    checkOutput("b1_underrun", underrun, 0);

    // Period with duty 0x40; queue 0x80 attenuated by 1.
    atten = 3'd1;
    measurePeriod(1'b1, 0, 8'h80, highs, adj, first);
    checkOutput("pwm40_highs",   highs, 64);
    checkOutput("pwm40_latency", first, 1);
    checkOutput("pwm40_underrun", underrun, 0);

    // Duty 0x80>>1; queue 0xFF attenuated by 7.
    atten = 3'd7;
    measurePeriod(1'b1, 0, 8'hFF, highs, adj, first);
    checkOutput("att1_highs", highs, 64);

    // Duty 0xFF>>7 = 1; queue 0x40 for sigma-delta.
    applyStimulus(8'h00, 1'b0, 1'b1, 3'd0);
    measurePeriod(1'b1, 0, 8'h40, highs, adj, first);
    checkOutput("att7_highs", highs, 1);

    // Sigma-delta at 0x40; queue 0x00 still in sigma-delta.
    measurePeriod(1'b1, 0, 8'h00, highs, adj, first);
    checkOutput("sd40_ones",     highs, 64);
    checkOutput("sd40_adjacent", adj, 0);
    checkOutput("sd40_strobe",   periodStrobe, 1);

    // Sigma-delta at 0x00 while filling the FIFO for PWM.
    modeIn = 1'b0;
    inValid  = 1'b1;
    inSample = 8'h10;
    @(negedge clk); inSample = 8'h20;
    @(negedge clk); inSample = 8'h30;
    @(negedge clk); inSample = 8'h50;
    @(negedge clk); inSample = 8'h60;
    checkOutput("full_level", fifoLevel, 4);
    checkOutput("full_ready", inReady, 0);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("full_reject_level", fifoLevel, 4);
    highs = 0;
    while ((cyc % 256) != 0) begin
      @(negedge clk);
      if (pwmOut === 1'b1) highs++;
    end
    checkOutput("sd00_ones",  highs, 0);
    checkOutput("pop_level",  fifoLevel, 3);

    // PWM 0x10; push 0x70 on the boundary cycle so push and pop coincide.
    measurePeriod(1'b1, 255, 8'h70, highs, adj, first);
    checkOutput("pwm10_highs",    highs, 16);
    checkOutput("pushpop_level",  fifoLevel, 3);

    measurePeriod(1'b0, 0, 8'h00, highs, adj, first);
    checkOutput("pwm20_highs", highs, 32);
    measurePeriod(1'b0, 0, 8'h00, highs, adj, first);
    checkOutput("pwm30_highs", highs, 48);
    measurePeriod(1'b0, 0, 8'h00, highs, adj, first);
    checkOutput("pwm50_highs", highs, 80);
    checkOutput("drain_level", fifoLevel, 0);
    checkOutput("drain_underrun_pre", underrun, 0);
    measurePeriod(1'b0, 0, 8'h00, highs, adj, first);
    checkOutput("pwm70_highs",    highs, 112);
    checkOutput("underrun_set",   underrun, 1);

    // Empty FIFO: last duty repeats.
    measurePeriod(1'b0, 0, 8'h00, highs, adj, first);
    checkOutput("repeat_highs", highs, 112);

    // Plain clear, then clear coinciding with a new underrun.
    repeat (5) @(negedge clk);
    underrunClr = 1'b1;
    @(negedge clk);
    underrunClr = 1'b0;
    checkOutput("underrun_clr", underrun, 0);
    goToCount(255);
    underrunClr = 1'b1;
    @(negedge clk);
    underrunClr = 1'b0;
    checkOutput("underrun_set_wins", underrun, 1);

    // Queue 0xC0 plus one more, reset mid-period while the output is high.
    inSample = 8'hC0;
    inValid  = 1'b1;
    @(negedge clk); inSample = 8'h11;
    @(negedge clk); inValid = 1'b0;
    goToCount(0);
    repeat (10) @(negedge clk);
    checkOutput("pre_reset_pwm",   pwmOut, 1);
    checkOutput("pre_reset_level", fifoLevel, 1);
    #2;
    RSTb = 1'b0;
    #1;
    checkOutput("async_pwm",      pwmOut, 0);
    checkOutput("async_level",    fifoLevel, 0);
    checkOutput("async_underrun", underrun, 0);
    checkOutput("async_ready",    inReady, 1);
    repeat (2) @(negedge clk);
    RSTb = 1'b1;
    highs = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwmOut !== 1'b0) highs++;
    end
    checkOutput("post_reset_pwm_quiet", highs, 0);
    checkOutput("post_reset_underrun",  underrun, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
